mc_control_fsm: RTL

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_pkg.sv | 35 +++
 rtl/mc_wait_counter.sv | 39 +++
 rtl/mc_control_fsm.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared opcodes, controller state enumeration and datapath select encodings
// for the multicycle MIPS control FSM.
// Contents: opcode constants, alu_op / alu_src_b / pc_src encodings, state_t, is_mem_wait().
package mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_BRANCH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_TARGET = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      REXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
   } state_t;

   // States that sit waiting on the unified memory handshake.
   function automatic logic is_mem_wait(state_t s);
      return s == FETCH || s == MEMRD || s == MEMWR;
   endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// mc_wait_counter: counts consecutive mem_ready-low cycles in memory-wait states and
// raises a sticky timeout flag once WAIT_MAX such cycles have elapsed.
// Ports: clk, rst_n (async active-low), state (current FSM state), mem_ready,
//        hit (this cycle is the WAIT_MAX-th stalled cycle), mem_timeout (sticky flag).
module mc_wait_counter
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic   clk,
   input  logic   rst_n,
   input  state_t state,
   input  logic   mem_ready,
   output logic   hit,
   output logic   mem_timeout
);

   localparam int CW = $clog2(WAIT_MAX + 1);

   logic [CW-1:0] count;
   logic          stalled;

   assign stalled = is_mem_wait(state) && !mem_ready;
   // Fires in the cycle whose edge would bring the count to WAIT_MAX.
   assign hit     = stalled && (count == CW'(WAIT_MAX - 1));

   // Any non-stalled cycle in a wait state leaves it, and every other state lasts one
   // cycle, so clearing whenever not stalled clears the count on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         mem_timeout <= 1'b0;
      end else begin
         count <= (stalled && !hit) ? count + 1'b1 : '0;
         if (hit) mem_timeout <= 1'b1;
      end
   end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main controller (fetch/decode/execute FSM) with a
// memory-wait timeout. Optional macro MC_CTRL_JUMP_EN adds the JUMP state for j.
// Ports: clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready, zero;
//        datapath controls pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//        mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src;
//        illegal (one-cycle pulse), mem_timeout (sticky), state (debug).
module mc_control_fsm
   import mc_pkg::*;
#(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       illegal,
   output logic       mem_timeout,
   output logic [3:0] state
);

   state_t cur, state_next;
   logic   hit;

   // The branch decision is pc_write_cond & zero, formed in the datapath.
   logic unused_zero;
   assign unused_zero = zero;

   mc_wait_counter #(.WAIT_MAX(WAIT_MAX)) u_wait (
      .clk        (clk),
      .rst_n      (rst_n),
      .state      (cur),
      .mem_ready  (mem_ready),
      .hit        (hit),
      .mem_timeout(mem_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= FETCH;
      else        cur <= state_next;
   end

   assign state = cur;

   // Outputs stay low while rst_n is asserted: FETCH would otherwise raise ir_write and
   // pc_write on mem_ready before the reset is released. A timeout drops every strobe.
   always_comb begin
      state_next    = cur;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = ALU_ADD;
      pc_src        = PC_ALU;
      illegal       = 1'b0;
      if (!rst_n || hit) begin
         state_next = FETCH;
      end else begin
         case (cur)
            FETCH: if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               alu_src_b  = SRCB_FOUR;
               pc_src     = PC_ALU;
               state_next = DECODE;
            end
            DECODE: begin
               alu_src_b = SRCB_BRANCH;
               case (opcode)
                  OP_LW, OP_SW: state_next = MEMADR;
                  OP_RTYPE:     state_next = REXEC;
                  OP_BEQ:       state_next = BRANCH;
                  OP_ADDI:      state_next = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
                  OP_J:         state_next = JUMP;
`endif
                  default: begin
                     illegal    = 1'b1;
                     state_next = FETCH;
                  end
               endcase
            end
            MEMADR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRCB_IMM;
               state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
               if (mem_ready) state_next = MEMWB;
            end
            MEMWR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
               if (mem_ready) state_next = FETCH;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               state_next = FETCH;
            end
            REXEC: begin
               alu_op     = ALU_FUNCT;
               state_next = ALUWB;
            end
            ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               state_next = FETCH;
            end
            BRANCH: begin
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_src        = PC_TARGET;
               state_next    = FETCH;
            end
            ADDIEX: begin
               alu_src_a  = 1'b1;
               alu_src_b  = SRCB_IMM;
               alu_op     = ALU_ADD;
               state_next = ADDIWB;
            end
            ADDIWB: begin
               reg_write  = 1'b1;
               state_next = FETCH;
            end
`ifdef MC_CTRL_JUMP_EN
            JUMP: begin
               pc_write   = 1'b1;
               pc_src     = PC_JUMP;
               state_next = FETCH;
            end
`endif
            default: state_next = FETCH;
         endcase
      end
   end

endmodule
